// File: rtl/pipo_pkg.sv
// Shared definitions for the pipo arbiter slice: FSM state encoding,
// default data width and a constant-foldable ceil(log2) helper.
package pipo_pkg;

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] GRANT = 2'd1;
    localparam logic [1:0] HOLD  = 2'd2;

    localparam int PIPO_W_DEFAULT = 4;

    // Never returns less than 1 so single-entry ranges still get a real bit.
    function automatic int clog2(input int value);
        int res;
        res = 1;
        for (int i = 1; i < 31; i++) begin
            if ((32'sd1 << i) < value) begin
                res = i + 1;
            end
        end
        return res;
    endfunction

endpackage

// File: rtl/pipo_arbiter_if.sv
// Requester/consumer bus of the pipo arbiter; slave is the arbiter side.
interface pipo_arbiter_if
    import pipo_pkg::*;
#(
    parameter int N = 4,
    parameter int W = PIPO_W_DEFAULT
) ();

    logic [N-1:0]          req;
    logic [N*W-1:0]        wdata;
    logic                  rd_ack;
    logic [N-1:0]          gnt;
    logic [W-1:0]          q;
    logic                  q_valid;
    logic [clog2(N)-1:0]   q_owner;
    logic                  timeout_err;

    modport slave (
        input  req, wdata, rd_ack,
        output gnt, q, q_valid, q_owner, timeout_err
    );

    modport master (
        output req, wdata, rd_ack,
        input  gnt, q, q_valid, q_owner, timeout_err
    );

endinterface

// File: rtl/rr_pick.sv
// Combinational round-robin picker: first set request at or above ptr, wrapping.
module rr_pick
    import pipo_pkg::*;
#(
    parameter int N = 4,
    localparam int IW = clog2(N)
) (
    input  logic [N-1:0]  req,
    input  logic [IW-1:0] ptr,
    output logic          any,
    output logic [IW-1:0] idx
);

    // Scan from the farthest offset down so the nearest hit is written last.
    always_comb begin
        int   pos_s;
        logic hit_s;
        any   = 1'b0;
        idx   = {IW{1'b0}};
        pos_s = 0;
        hit_s = 1'b0;
        for (int i = N - 1; i >= 0; i--) begin
            pos_s = (int'(ptr) + i) % N;
            hit_s = req[IW'(pos_s)];
            any   = any | hit_s;
            idx   = hit_s ? IW'(pos_s) : idx;
        end
    end

endmodule

// File: rtl/pipo_arbiter.sv
// Round-robin arbiter sequencing loads of N requesters into one shared
// W-bit holding register, with consumer acknowledge and hold timeout.
module pipo_arbiter
    import pipo_pkg::*;
#(
    parameter int N        = 4,
    parameter int W        = PIPO_W_DEFAULT,
    parameter int HOLD_MAX = 15
) (
    input  logic          clk,
    input  logic          reset,
    pipo_arbiter_if.slave bus
);

    localparam int IW = clog2(N);
    localparam int CW = clog2(HOLD_MAX + 1);
    localparam logic [IW-1:0] LAST_IDX  = IW'(N - 1);
    localparam logic [N-1:0]  ONEHOT_LO = {{(N-1){1'b0}}, 1'b1};

    logic [1:0]    state_r;
    logic [IW-1:0] ptr_r;
    logic [IW-1:0] owner_r;
    logic [CW-1:0] cnt_r;
    logic [N-1:0]  gnt_r;
    logic [W-1:0]  q_r;
    logic          q_valid_r;
    logic          timeout_r;

    logic [IW-1:0] next_ptr_s;
    logic [IW-1:0] pick_ptr_s;
    logic [IW-1:0] pick_idx_s;
    logic          pick_any_s;
    logic [W-1:0]  sel_word_s;

    // Pointer after the current owner; in HOLD it steers the back-to-back pick.
    always_comb begin
        next_ptr_s = (owner_r == LAST_IDX) ? {IW{1'b0}} : owner_r + IW'(1);
        if (state_r == HOLD) begin
            pick_ptr_s = next_ptr_s;
        end else begin
            pick_ptr_s = ptr_r;
        end
    end

    // Word of the owning requester, presented to the holding register.
    always_comb begin
        sel_word_s = {W{1'b0}};
        for (int i = 0; i < N; i++) begin
            sel_word_s = (owner_r == IW'(i)) ? bus.wdata[i*W +: W] : sel_word_s;
        end
    end

    rr_pick #(.N(N)) u_pick (
        .req (bus.req),
        .ptr (pick_ptr_s),
        .any (pick_any_s),
        .idx (pick_idx_s)
    );

    // Arbitration FSM and the inline holding register.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            state_r   <= IDLE;
            ptr_r     <= {IW{1'b0}};
            owner_r   <= {IW{1'b0}};
            cnt_r     <= {CW{1'b0}};
            gnt_r     <= {N{1'b0}};
            q_r       <= {W{1'b0}};
            q_valid_r <= 1'b0;
            timeout_r <= 1'b0;
        end else begin
            timeout_r <= 1'b0;
            case (state_r)
                IDLE: begin
                    if (pick_any_s) begin
                        gnt_r   <= ONEHOT_LO << pick_idx_s;
                        owner_r <= pick_idx_s;
                        state_r <= GRANT;
                    end
                end
                GRANT: begin
                    q_r       <= sel_word_s;
                    q_valid_r <= 1'b1;
                    gnt_r     <= {N{1'b0}};
                    cnt_r     <= {CW{1'b0}};
                    state_r   <= HOLD;
                end
                HOLD: begin
                    if (bus.rd_ack) begin
                        q_valid_r <= 1'b0;
                        ptr_r     <= next_ptr_s;
                        if (pick_any_s) begin
                            gnt_r   <= ONEHOT_LO << pick_idx_s;
                            owner_r <= pick_idx_s;
                            state_r <= GRANT;
                        end else begin
                            state_r <= IDLE;
                        end
                    end else if (cnt_r == CW'(HOLD_MAX - 1)) begin
                        // Forced release: q keeps its word, only validity drops.
                        q_valid_r <= 1'b0;
                        timeout_r <= 1'b1;
                        ptr_r     <= next_ptr_s;
                        state_r   <= IDLE;
                    end else begin
                        cnt_r <= cnt_r + CW'(1);
                    end
                end
                default: begin
                    gnt_r     <= {N{1'b0}};
                    q_valid_r <= 1'b0;
                    state_r   <= IDLE;
                end
            endcase
        end
    end

    assign bus.gnt         = gnt_r;
    assign bus.q           = q_r;
    assign bus.q_valid     = q_valid_r;
    assign bus.q_owner     = owner_r;
    assign bus.timeout_err = timeout_r;

endmodule
